// File: rtl/usb_packet_demux.sv
// Routes fixed-length packets to a data or control channel from the header word.
// Define USB_DEMUX_DROP_CNT_EN to build the saturating dropped-packet counter.
module usb_packet_demux #(
   parameter int NUM_CHAN   = 2,
   parameter int FIFO_WIDTH = 32,
   parameter int PKT_WORDS  = 128,
   parameter int CHAN_LSB   = 16,
   parameter int CHAN_W     = 5,
   parameter int CTRL_CODE  = 31,
   parameter int DROP_CNT_W = 16
) (
   input  logic                  txclk,
   input  logic                  reset,
   input  logic                  WR_in,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic [NUM_CHAN:0]     chan_space,
   output logic [NUM_CHAN:0]     WR_channel,
   output logic [FIFO_WIDTH-1:0] ram_data,
   output logic [NUM_CHAN:0]     WR_done_channel,
   output logic                  pkt_active,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam int CNT_W  = $clog2(PKT_WORDS + 1);
   localparam int DEST_W = (NUM_CHAN > 0) ? $clog2(NUM_CHAN + 1) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FORWARD = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   localparam logic [CHAN_W-1:0]   CTRL  = CHAN_W'(CTRL_CODE);
   localparam logic [CHAN_W-1:0]   NDATA = CHAN_W'(NUM_CHAN);
   localparam logic [CNT_W-1:0]    LAST  = CNT_W'(PKT_WORDS - 1);
   localparam logic [NUM_CHAN:0]   ONE   = (NUM_CHAN + 1)'(1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  word_cnt;
   logic [DEST_W-1:0] dest;

   logic [CHAN_W-1:0] code;
   logic              hdr_valid;
   logic [DEST_W-1:0] hdr_dest;
   logic              hdr_ok;

   // Control code wins if it ever overlaps a data channel number
   always_comb begin
      code      = data_in[CHAN_LSB +: CHAN_W];
      hdr_valid = 1'b0;
      hdr_dest  = '0;
      if (code == CTRL) begin
         hdr_valid = 1'b1;
         hdr_dest  = DEST_W'(NUM_CHAN);
      end else if (code < NDATA) begin
         hdr_valid = 1'b1;
         hdr_dest  = DEST_W'(code);
      end
      hdr_ok = hdr_valid && chan_space[hdr_dest];
   end

   always_ff @(posedge txclk) begin
      if (reset) begin
         state           <= IDLE;
         word_cnt        <= '0;
         dest            <= '0;
         WR_channel      <= '0;
         WR_done_channel <= '0;
         ram_data        <= '0;
         pkt_active      <= 1'b0;
      end else begin
         WR_channel      <= '0;
         WR_done_channel <= '0;
         if (WR_in) begin
            case (state)
               IDLE: begin
                  word_cnt   <= CNT_W'(1);
                  pkt_active <= 1'b1;
                  if (hdr_ok) begin
                     state      <= FORWARD;
                     dest       <= hdr_dest;
                     WR_channel <= ONE << hdr_dest;
                     ram_data   <= data_in;
                  end else begin
                     state <= DISCARD;
                  end
               end
               FORWARD: begin
                  WR_channel <= ONE << dest;
                  ram_data   <= data_in;
                  if (word_cnt == LAST) begin
                     WR_done_channel <= ONE << dest;
                     state           <= IDLE;
                     word_cnt        <= '0;
                     pkt_active      <= 1'b0;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
               DISCARD: begin
                  if (word_cnt == LAST) begin
                     state      <= IDLE;
                     word_cnt   <= '0;
                     pkt_active <= 1'b0;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state      <= IDLE;
                  word_cnt   <= '0;
                  pkt_active <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef USB_DEMUX_DROP_CNT_EN
   logic drop;

   assign drop = WR_in && (state == IDLE) && !hdr_ok;

   always_ff @(posedge txclk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + DROP_CNT_W'(1);
      end
   end
`else
   assign drop_count = '0;
`endif

endmodule
